// File: rtl/keycode_act_if.sv
// ============================================================================
// keycode_act_if : valid/ready action channel from the keycode scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

interface keycode_act_if;
    logic       act_valid;
    logic [1:0] act_kind;
    logic       act_ready;

    modport master (output act_valid, output act_kind, input act_ready);
    modport slave  (input act_valid, input act_kind, output act_ready);
endinterface

`default_nettype wire

// File: rtl/keycode_action_sched.sv
// ============================================================================
// keycode_action_sched : key presses -> queued game actions, one per frame
// Rev 1.0 | optional auto-repeat flap: KEYCODE_SCHED_AUTOREPEAT_EN
// ============================================================================
`default_nettype none

module keycode_action_sched #(
    parameter int         DEPTH         = 4,
    parameter int         REPEAT_FRAMES = 8,
    parameter logic [7:0] FLAP_CODE     = 8'h2C,
    parameter logic [7:0] START_CODE    = 8'h28,
    parameter logic [7:0] PAUSE_CODE    = 8'h13
) (
    input  wire logic                     clk,
    input  wire logic                     reset_n,
    input  wire logic [7:0]               keycode,
    input  wire logic                     frame_start,
    input  wire logic                     ovf_clr,
    output logic      [$clog2(DEPTH):0]   q_count,
    output logic                          overflow,
    keycode_act_if.master                 act
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("DEPTH must be a power of two in 2..16");
    end
    if ((REPEAT_FRAMES < 1) || (REPEAT_FRAMES > 255)) begin : g_bad_repeat
        $error("REPEAT_FRAMES must be in 1..255");
    end

    typedef enum logic [0:0] {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    state_t          state, state_nxt;
    logic [7:0]      prev;
    logic            armed;
    logic [1:0]      key_kind;
    logic            press_evt;
    logic            rep_evt;
    logic            push;
    logic [1:0]      push_kind;
    logic            pop;
    logic            full;
    logic            wr_en;
    logic            drop;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [1:0]      mem [DEPTH];

    always_comb begin
        key_kind = 2'd0;
        if (keycode == FLAP_CODE)       key_kind = 2'd1;
        else if (keycode == START_CODE) key_kind = 2'd2;
        else if (keycode == PAUSE_CODE) key_kind = 2'd3;
    end

    // armed masks the first edge after reset so a key held through reset
    // only reloads prev instead of looking like a fresh press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev  <= 8'd0;
            armed <= 1'b0;
        end else begin
            prev  <= keycode;
            armed <= 1'b1;
        end
    end

    assign press_evt = armed && (keycode != prev) && (keycode != 8'd0) && (key_kind != 2'd0);

`ifdef KEYCODE_SCHED_AUTOREPEAT_EN
    logic [7:0] rep_cnt;
    logic       held_flap;

    assign held_flap = (keycode == FLAP_CODE) && (keycode == prev);
    assign rep_evt   = held_flap && frame_start && (rep_cnt == 8'(REPEAT_FRAMES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rep_cnt <= 8'd0;
        end else if (!held_flap || rep_evt) begin
            rep_cnt <= 8'd0;
        end else if (frame_start) begin
            rep_cnt <= rep_cnt + 8'd1;
        end
    end
`else
    assign rep_evt = 1'b0;
`endif

    assign push      = press_evt || rep_evt;
    assign push_kind = press_evt ? key_kind : 2'd1;
    assign full      = (q_count == CW'(DEPTH));
    assign pop       = (state == ISSUE) && act.act_ready;
    assign wr_en     = push && (!full || pop);
    assign drop      = push && full && !pop;

    // When full, wr_ptr == rd_ptr: the head is read before the same slot is
    // overwritten, so a simultaneous push lands behind everything else.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_kind;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            q_count  <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   q_count <= q_count + 1'b1;
                2'b01:   q_count <= q_count - 1'b1;
                default: q_count <= q_count;
            endcase
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        act.act_valid = 1'b0;
        act.act_kind  = 2'd0;
        case (state)
            IDLE: begin
                if (frame_start && (q_count != '0)) state_nxt = ISSUE;
            end
            ISSUE: begin
                act.act_valid = 1'b1;
                act.act_kind  = mem[rd_ptr];
                if (act.act_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_keycode_action_sched.sv
// ============================================================================
// tb_keycode_action_sched : directed self-checking bench for the scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_keycode_action_sched;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] keycode = 8'd0;
    logic       frame_start = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [2:0] q_count;
    logic       overflow;
    int         total = 0;
    int         bad = 0;

`ifdef KEYCODE_SCHED_AUTOREPEAT_EN
    localparam int EXP_FLAPS = 3;
`else
    localparam int EXP_FLAPS = 1;
`endif

    keycode_act_if act ();

    keycode_action_sched #(.DEPTH(4), .REPEAT_FRAMES(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .keycode     (keycode),
        .frame_start (frame_start),
        .ovf_clr     (ovf_clr),
        .q_count     (q_count),
        .overflow    (overflow),
        .act         (act)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        act.act_ready = 1'b0;
        #2;
        total++; if (act.act_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0b want 0", act.act_valid); end
        total++; if (act.act_kind !== 2'd0) begin bad++; $display("FAIL rst_kind: got %0d want 0", act.act_kind); end
        total++; if (q_count !== 3'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", q_count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %0b want 0", overflow); end
        step();
        reset_n = 1'b1;
        step();
        keycode = 8'h2C;
        step();
        total++; if (q_count !== 3'd1) begin bad++; $display("FAIL pre_rst_push: got %0d want 1", q_count); end
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        total++; if (act.act_valid !== 1'b1) begin bad++; $display("FAIL pre_rst_issue: got %0b want 1", act.act_valid); end
        #2 reset_n = 1'b0;
        #1;
        total++; if ({act.act_valid, act.act_kind} !== 3'b000) begin bad++; $display("FAIL midrst_act: got %0h want 0", {act.act_valid, act.act_kind}); end
        total++; if (q_count !== 3'd0) begin bad++; $display("FAIL midrst_count: got %0d want 0", q_count); end
        step();
        step();
        reset_n = 1'b1;
        repeat (3) step();
        total++; if (q_count !== 3'd0) begin bad++; $display("FAIL held_after_rst: got %0d want 0", q_count); end
        total++; if (act.act_valid !== 1'b0) begin bad++; $display("FAIL held_after_rst_valid: got %0b want 0", act.act_valid); end
        keycode = 8'h00;
        step();
    endtask

    task automatic test_single_flap();
        keycode = 8'h2C;
        act.act_ready = 1'b1;
        step();
        total++; if (q_count !== 3'd1) begin bad++; $display("FAIL flap_push: got %0d want 1", q_count); end
        total++; if (act.act_valid !== 1'b0) begin bad++; $display("FAIL flap_no_early: got %0b want 0", act.act_valid); end
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        total++; if ({act.act_valid, act.act_kind} !== 3'b101) begin bad++; $display("FAIL flap_issue: got %0h want 5", {act.act_valid, act.act_kind}); end
        step();
        total++; if (act.act_valid !== 1'b0) begin bad++; $display("FAIL flap_one_cycle: got %0b want 0", act.act_valid); end
        total++; if (q_count !== 3'd0) begin bad++; $display("FAIL flap_popped: got %0d want 0", q_count); end
        keycode = 8'h00;
        step();
    endtask

    task automatic test_same_edge_push();
        act.act_ready = 1'b1;
        keycode = 8'h2C;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        total++; if (q_count !== 3'd1) begin bad++; $display("FAIL same_edge_count: got %0d want 1", q_count); end
        total++; if (act.act_valid !== 1'b0) begin bad++; $display("FAIL same_edge_valid: got %0b want 0", act.act_valid); end
        step();
        total++; if (act.act_valid !== 1'b0) begin bad++; $display("FAIL same_edge_wait: got %0b want 0", act.act_valid); end
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        total++; if ({act.act_valid, act.act_kind} !== 3'b101) begin bad++; $display("FAIL same_edge_issue: got %0h want 5", {act.act_valid, act.act_kind}); end
        step();
        total++; if (q_count !== 3'd0) begin bad++; $display("FAIL same_edge_pop: got %0d want 0", q_count); end
        keycode = 8'h00;
        step();
    endtask

    task automatic test_overflow();
        logic [7:0] seq [9] = '{8'h2C, 8'h00, 8'h28, 8'h00, 8'h13, 8'h00, 8'h2C, 8'h00, 8'h28};
        for (int i = 0; i < 9; i++) begin
            keycode = seq[i];
            step();
            if (i == 6) begin
                total++; if ({overflow, q_count} !== 4'b0100) begin bad++; $display("FAIL ovf_fill4: got ovf=%0b cnt=%0d want ovf=0 cnt=4", overflow, q_count); end
            end
        end
        total++; if (q_count !== 3'd4) begin bad++; $display("FAIL ovf_count: got %0d want 4", q_count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %0b want 1", overflow); end
        keycode = 8'h00;
        ovf_clr = 1'b1;
        step();
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr: got %0b want 0", overflow); end
        keycode = 8'h2C;
        step();
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set_wins: got %0b want 1", overflow); end
        step();
        ovf_clr = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_reclr: got %0b want 0", overflow); end
        keycode = 8'h00;
        step();
    endtask

    task automatic test_full_push_pop();
        logic [1:0] exp_kind [4] = '{2'd2, 2'd3, 2'd1, 2'd3};
        act.act_ready = 1'b0;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        total++; if ({act.act_valid, act.act_kind} !== 3'b101) begin bad++; $display("FAIL full_head: got %0h want 5", {act.act_valid, act.act_kind}); end
        keycode = 8'h13;
        act.act_ready = 1'b1;
        step();
        total++; if (q_count !== 3'd4) begin bad++; $display("FAIL full_pp_count: got %0d want 4", q_count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_pp_ovf: got %0b want 0", overflow); end
        keycode = 8'h00;
        for (int i = 0; i < 4; i++) begin
            frame_start = 1'b1;
            step();
            frame_start = 1'b0;
            total++; if ({act.act_valid, act.act_kind} !== {1'b1, exp_kind[i]}) begin bad++; $display("FAIL drain_%0d: got %0h want %0h", i, {act.act_valid, act.act_kind}, {1'b1, exp_kind[i]}); end
            step();
        end
        total++; if (q_count !== 3'd0) begin bad++; $display("FAIL drain_empty: got %0d want 0", q_count); end
    endtask

    task automatic test_hold_ready();
        int held_bad = 0;
        keycode = 8'h28; step();
        keycode = 8'h00; step();
        keycode = 8'h13; step();
        keycode = 8'h00; step();
        total++; if (q_count !== 3'd2) begin bad++; $display("FAIL hold_fill: got %0d want 2", q_count); end
        act.act_ready = 1'b0;
        frame_start = 1'b1;
        step();
        for (int c = 0; c < 10; c++) begin
            frame_start = (c == 3) || (c == 7);
            step();
            if ({act.act_valid, act.act_kind} !== 3'b110) held_bad++;
        end
        frame_start = 1'b0;
        total++; if (held_bad !== 0) begin bad++; $display("FAIL hold_stable: got %0d unstable cycles want 0", held_bad); end
        act.act_ready = 1'b1;
        step();
        total++; if ({act.act_valid, q_count} !== 4'b0001) begin bad++; $display("FAIL hold_pop: got valid=%0b cnt=%0d want valid=0 cnt=1", act.act_valid, q_count); end
        repeat (3) step();
        total++; if (act.act_valid !== 1'b0) begin bad++; $display("FAIL hold_not_banked: got %0b want 0", act.act_valid); end
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        total++; if ({act.act_valid, act.act_kind} !== 3'b111) begin bad++; $display("FAIL hold_pause: got %0h want 7", {act.act_valid, act.act_kind}); end
        step();
        total++; if (q_count !== 3'd0) begin bad++; $display("FAIL hold_empty: got %0d want 0", q_count); end
    endtask

    task automatic test_unmapped_hold();
        int flaps = 0;
        act.act_ready = 1'b1;
        keycode = 8'h04;
        repeat (2) step();
        total++; if (q_count !== 3'd0) begin bad++; $display("FAIL unmapped: got %0d want 0", q_count); end
        keycode = 8'h00; step();
        keycode = 8'h2C; step();
        for (int f = 0; f < 22; f++) begin
            if (f == 20) keycode = 8'h00;
            frame_start = 1'b1;
            step();
            frame_start = 1'b0;
            if (act.act_valid && act.act_kind == 2'd1) flaps++;
            for (int k = 0; k < 3; k++) begin
                step();
                if (act.act_valid && act.act_kind == 2'd1) flaps++;
            end
        end
        total++; if (flaps !== EXP_FLAPS) begin bad++; $display("FAIL hold_flaps: got %0d want %0d", flaps, EXP_FLAPS); end
        total++; if ({overflow, q_count} !== 4'b0000) begin bad++; $display("FAIL hold_end: got ovf=%0b cnt=%0d want 0/0", overflow, q_count); end
    endtask

    initial begin
        test_reset();
        test_single_flap();
        test_same_edge_push();
        test_overflow();
        test_full_push_pop();
        test_hold_ready();
        test_unmapped_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/keycode_action_sched.md
# keycode_action_sched

Keycode-to-action scheduler for the FlappyBird SoC. It watches the 8-bit keycode that the NIOS software drives from the USB keyboard into the keycode PIO. It turns new key presses into game actions (flap, start, pause) and queues them in a small FIFO. It releases at most one action per video frame to the game logic through a valid/ready handshake. It sits between the keycode PIO `out_port` and the game-state/bird-motion logic.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `REPEAT_FRAMES`, 8: frames between auto-repeat flaps; 1..255. Used only with the macro in Configuration.
- `FLAP_CODE`, 8'h2C: keycode mapped to FLAP (space).
- `START_CODE`, 8'h28: keycode mapped to START (enter).
- `PAUSE_CODE`, 8'h13: keycode mapped to PAUSE (P).

Ports:
- `clk`  in  1  system clock. One clock only; all logic on rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `keycode`  in  8  keycode from the PIO. Synchronous to `clk`. 0 means no key.
- `frame_start`  in  1  one-cycle pulse per frame (vsync).
- `act_ready`  in  1  game logic accepts the action.
- `act_valid`  out  1  action offered.
- `act_kind`  out  2  action code: 1 = FLAP, 2 = START, 3 = PAUSE, 0 when `act_valid` = 0.
- `q_count`  out  clog2(DEPTH)+1  FIFO occupancy.
- `overflow`  out  1  sticky: an event was dropped.
- `ovf_clr`  in  1  clears `overflow`.

## Operation
- **Press detection**
  - Register `prev` holds `keycode` from the previous cycle.
  - Event when `keycode != prev`, `keycode != 0`, and `keycode` matches a mapped code.
  - Release (0) and unmapped codes produce no event.
  - A direct change between two mapped codes is an event for the new code.
- **FIFO**: circular, `DEPTH` entries of 2 bits, with read/write pointers and a count.
  - Push on an event edge.
  - Push when full with no pop in the same cycle: entry dropped, `overflow` <= 1.
  - Push and pop in the same cycle: both occur; count unchanged, even when full; no overflow.
  - Pointers wrap modulo `DEPTH`.
- **`overflow` flag**
  - `ovf_clr` clears it.
  - When `ovf_clr` and a drop occur in the same cycle, set wins.
- **Scheduler FSM**
  - IDLE: on `frame_start` = 1 with registered `q_count` > 0, go to ISSUE. Otherwise stay.
  - ISSUE: `act_valid` = 1, `act_kind` = FIFO head.
    - On `act_ready` = 1: pop and return to IDLE.
    - `frame_start` pulses arriving in ISSUE are ignored and not banked.
- **Reset**: asynchronous; clears pointers, count, `prev` (to 0), `overflow`, and FSM (to IDLE). Reset in ISSUE drops the offered action.

## Timing
- **Reset values**: `act_valid` = 0, `act_kind` = 0, `q_count` = 0, `overflow` = 0.
- **Push latency**: the keycode change is sampled at edge E; `q_count` increments after E.
- **Issue latency**: `frame_start` is sampled at edge F in IDLE; `act_valid` rises after F, a 1-cycle latency.
  - A push at the same edge F onto an empty FIFO is not issued. It waits for the next `frame_start`.
- **Handshake**
  - The transfer occurs at the edge where `act_valid` and `act_ready` are both 1.
  - `act_valid` falls after that edge; `q_count` decrements after that edge.
  - While `act_valid` = 1 and `act_ready` = 0, `act_kind` is held stable.
- **Throughput**: at most one action per frame.
- **Overflow**: `overflow` rises the cycle after the dropping edge.

## Configuration
- Macro: `KEYCODE_SCHED_AUTOREPEAT_EN`.
- **Defined**
  - An 8-bit frame counter runs while `keycode == FLAP_CODE` and `keycode == prev`. It counts `frame_start` pulses.
  - When the counter reaches `REPEAT_FRAMES`, a FLAP push is generated and the counter clears.
  - The counter clears on any keycode change and on reset.
  - Repeat pushes follow the same full/overflow rules as press events.
- **Undefined**: no counter is built. A held key yields exactly one event.

## Test plan
- Reset asserted mid-run with `keycode` = 8'h2C → all outputs 0 immediately. After release with `keycode` held at 2C, no event is generated, because `prev` reloads to 2C on the first edge.
- `keycode` 0→2C, then `frame_start` pulse, with `act_ready` = 1 → `q_count` 0→1; `act_valid` high for 1 cycle the cycle after the pulse with `act_kind` = 1; then `q_count` = 0.
- `DEPTH` = 4, no `frame_start`; presses 2C, 0, 28, 0, 13, 0, 2C, 0, 28 → `q_count` = 4, `overflow` = 1, the fifth event is dropped. Then `ovf_clr` → `overflow` = 0.
- FIFO holding {START, PAUSE}; `act_ready` = 0 for 10 cycles across 2 `frame_start` pulses → `act_valid` held with `act_kind` = 2 throughout. After `act_ready` = 1: pop, IDLE, `q_count` = 1. PAUSE is issued only on the next `frame_start`.
- Full FIFO with a push and pop at the same edge → `q_count` stays 4, `overflow` stays 0, and the new entry is last in order.
- `keycode` 8'h04 → no push. 2C held for 20 frames:
  - without the macro → exactly 1 FLAP;
  - with the macro and `REPEAT_FRAMES` = 8 → 3 FLAPs total (the press, plus the 8th and 16th frames).
